// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-back, write-allocate data cache with
// one-word lines. It serves the datapath dcache port and masters the memory
// controller port on misses and during the halt flush.
// Optional LL/SC support is enabled by defining DCACHE_LLSC_EN.
module dcache_direct #(
    parameter int SETS  = 16,
    parameter int WORDW = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             halt,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             datomic,
    input  logic [31:0]      dmemaddr,
    input  logic [WORDW-1:0] dmemstore,
    output logic             dhit,
    output logic [WORDW-1:0] dmemload,
    output logic             flushed,
    output logic             dREN,
    output logic             dWEN,
    output logic [31:0]      daddr,
    output logic [WORDW-1:0] dstore,
    input  logic             dwait,
    input  logic [WORDW-1:0] dload
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, FLUSH_WB, DONE} state_t;

    state_t           r_state, w_next;
    logic [SETS-1:0]  r_valid, r_dirty;
    logic [TAGW-1:0]  r_tag  [SETS];
    logic [WORDW-1:0] r_data [SETS];
    logic [29:0]      r_maddr;
    logic [IDXW-1:0]  r_cnt;

    logic [IDXW-1:0]  w_idx, w_midx;
    logic [TAGW-1:0]  w_tag, w_mtag;
    logic             w_req, w_hit, w_serve, w_wr_hit, w_cnt_last;
    logic             w_sc, w_sc_fail;
    logic             w_unused;

    assign w_idx      = dmemaddr[IDXW+1:2];
    assign w_tag      = dmemaddr[31:IDXW+2];
    assign w_midx     = r_maddr[IDXW-1:0];
    assign w_mtag     = r_maddr[29:IDXW];
    assign w_req      = dmemREN | dmemWEN;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_serve    = (r_state == IDLE) && w_req && !halt;
    assign w_wr_hit   = w_serve && w_hit && dmemWEN && !w_sc_fail;
    assign w_cnt_last = (r_cnt == IDXW'(SETS - 1));
    assign w_unused   = ^{dmemaddr[1:0], datomic};

`ifdef DCACHE_LLSC_EN
    logic        r_link_valid;
    logic [29:0] r_link_addr;
    logic        w_ll;

    assign w_sc      = datomic & dmemWEN;
    assign w_ll      = datomic & dmemREN & ~dmemWEN;
    assign w_sc_fail = w_sc & ~(r_link_valid && (r_link_addr == dmemaddr[31:2]));

    // Link register: set by LL on its hit, cleared by reset, halt, or any write to the linked word
    always_ff @(posedge CLK) begin
        if (!nRST || halt) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (w_serve && w_hit && w_ll) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= dmemaddr[31:2];
        end else if (w_wr_hit && (r_link_addr == dmemaddr[31:2])) begin
            r_link_valid <= 1'b0;
        end
    end
`else
    assign w_sc      = 1'b0;
    assign w_sc_fail = 1'b0;
`endif

    // State register, line status bits, miss address latch and flush counter
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_maddr <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_cnt <= '0;
                    end else if (w_serve && !w_hit && !w_sc_fail) begin
                        r_maddr <= dmemaddr[31:2];
                    end
                    if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
                end
                WB: if (!dwait) r_dirty[w_midx] <= 1'b0;
                FETCH: if (!dwait) begin
                    r_valid[w_midx] <= 1'b1;
                    r_dirty[w_midx] <= 1'b0;
                end
                FLUSH: if (!r_dirty[r_cnt] && !w_cnt_last) r_cnt <= r_cnt + 1'b1;
                FLUSH_WB: if (!dwait) begin
                    r_dirty[r_cnt] <= 1'b0;
                    if (!w_cnt_last) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Line tag/data storage: write hits and fills; contents are don't-care while invalid
    always_ff @(posedge CLK) begin
        if (w_wr_hit) begin
            r_data[w_idx] <= dmemstore;
        end else if (r_state == FETCH && !dwait) begin
            r_data[w_midx] <= dload;
            r_tag[w_midx]  <= w_mtag;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next   = r_state;
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_next = FLUSH;
                end else if (w_req) begin
                    if (w_sc_fail) begin
                        dhit = 1'b1;
                    end else if (w_hit) begin
                        dhit     = 1'b1;
                        dmemload = w_sc ? WORDW'(1) : r_data[w_idx];
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        w_next = WB;
                    end else begin
                        w_next = FETCH;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[w_midx], w_midx, 2'b00};
                dstore = r_data[w_midx];
                if (!dwait) w_next = FETCH;
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {r_maddr, 2'b00};
                if (!dwait) w_next = IDLE;
            end
            FLUSH: begin
                if (r_dirty[r_cnt]) w_next = FLUSH_WB;
                else if (w_cnt_last) w_next = DONE;
            end
            FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[r_cnt], r_cnt, 2'b00};
                dstore = r_data[r_cnt];
                if (!dwait) w_next = w_cnt_last ? DONE : FLUSH;
            end
            DONE: flushed = 1'b1;
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: directed checks plus randomized traffic against a
// word-level memory model (the datapath must always observe the latest write).
module tb_dcache_direct;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait = 1'b1;
    logic [31:0] dload = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem   [logic [31:0]];
    logic [31:0] model [logic [31:0]];
    logic [64:0] evq [$];
    int          mem_lat = 0;
    int          mcnt = 0;
    int          ren_cyc = 0;

    dcache_direct #(.SETS(16), .WORDW(32)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] expv(input logic [31:0] a);
        return model.exists(a) ? model[a] : memrd(a);
    endfunction

    // Memory controller model: dwait decided per cycle, transfer commits on dwait=0
    always @(negedge CLK) begin
        check("no_ren_wen_overlap", {64'd0, dREN & dWEN}, 65'd0);
        if (dREN || dWEN) begin
            if (dREN) ren_cyc++;
            if (mcnt < mem_lat) begin
                dwait = 1'b1;
                mcnt++;
            end else begin
                dwait = 1'b0;
                mcnt  = 0;
                if (dWEN) begin
                    mem[daddr] = dstore;
                    evq.push_back({1'b1, daddr, dstore});
                end else begin
                    dload = memrd(daddr);
                    evq.push_back({1'b0, daddr, 32'h0});
                end
            end
        end else begin
            dwait = 1'b1;
            mcnt  = 0;
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic access(input logic ren, input logic wen, input logic atom,
                          input logic [31:0] a, input logic [31:0] d, input int maxc,
                          output logic [31:0] ld, output int cyc, output logic ok);
        @(posedge CLK); #1;
        dmemREN = ren; dmemWEN = wen; datomic = atom; dmemaddr = a; dmemstore = d;
        ok = 1'b0; cyc = 0; ld = '0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge CLK);
            cyc++;
            if (dhit === 1'b1) begin
                ld = dmemload;
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    endtask

    task automatic flush_wait(output int cyc, output logic got);
        @(posedge CLK); #1 halt = 1'b1;
        got = 1'b0; cyc = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            cyc++;
            if (flushed === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] ld, a, d, e;
        int          cyc, r0, kind;
        logic        ok;

        // reset state
        do_reset();
        @(negedge CLK);
        check("rst_dhit", dhit, 0);
        check("rst_flushed", flushed, 0);
        check("rst_dREN", dREN, 0);
        check("rst_dWEN", dWEN, 0);
        check("rst_daddr", daddr, 0);
        check("rst_dstore", dstore, 0);
        check("rst_dmemload", dmemload, 0);

        // cold read with 3 wait cycles, then a hit with no traffic
        mem[32'h40] = 32'hDEAD_BEEF;
        mem_lat = 3; r0 = ren_cyc; evq.delete();
        access(1, 0, 0, 32'h40, 0, 50, ld, cyc, ok);
        check("cold_ok", ok, 1);
        check("cold_data", ld, 32'hDEAD_BEEF);
        check("cold_dren_cycles", ren_cyc - r0, 4);
        evq.delete();
        access(1, 0, 0, 32'h40, 0, 50, ld, cyc, ok);
        check("rehit_data", ld, 32'hDEAD_BEEF);
        check("rehit_cycles", cyc, 1);
        check("rehit_no_traffic", evq.size(), 0);

        // write hit, then conflicting read forces writeback before the fetch
        mem_lat = 1;
        access(0, 1, 0, 32'h40, 32'h1234_5678, 50, ld, cyc, ok);
        check("wrhit_cycles", cyc, 1);
        check("wrhit_oldload", ld, 32'hDEAD_BEEF);
        evq.delete();
        access(1, 0, 0, 32'h80, 0, 50, ld, cyc, ok);
        check("conflict_data", ld, memrd(32'h80));
        check("conflict_nev", evq.size(), 2);
        if (evq.size() == 2) begin
            check("conflict_wb", evq[0], {1'b1, 32'h40, 32'h1234_5678});
            check("conflict_fetch", evq[1], {1'b0, 32'h80, 32'h0});
        end

        // REN and WEN together act as a write; eviction proves the line went dirty
        access(1, 1, 0, 32'h80, 32'hA5A5_A5A5, 50, ld, cyc, ok);
        check("renwen_hit", cyc, 1);
        evq.delete();
        access(1, 0, 0, 32'h40, 0, 50, ld, cyc, ok);
        check("renwen_reload", ld, 32'h1234_5678);
        check("renwen_wb", (evq.size() > 0) ? evq[0] : 65'd0, {1'b1, 32'h80, 32'hA5A5_A5A5});

        // reset while FETCH waits on dwait
        mem_lat = 10;
        @(posedge CLK); #1;
        dmemREN = 1'b1; dmemaddr = 32'h44;
        repeat (3) @(negedge CLK);
        check("midfetch_dREN", dREN, 1);
        nRST = 1'b0;
        @(negedge CLK);
        check("abort_dREN", dREN, 0);
        check("abort_dWEN", dWEN, 0);
        check("abort_daddr", daddr, 0);
        check("abort_dhit", dhit, 0);
        check("abort_dmemload", dmemload, 0);
        @(posedge CLK); #1;
        nRST = 1'b1; dmemREN = 1'b0;
        mem_lat = 0; evq.delete();
        access(1, 0, 0, 32'h40, 0, 50, ld, cyc, ok);
        check("post_rst_miss", cyc > 1, 1);
        check("post_rst_fetch", evq.size(), 1);
        check("post_rst_data", ld, 32'h1234_5678);

        // two dirty lines, then halt flush
        access(0, 1, 0, 32'h04, 32'h1111_0004, 50, ld, cyc, ok);
        access(0, 1, 0, 32'h08, 32'h2222_0008, 50, ld, cyc, ok);
        evq.delete();
        flush_wait(cyc, ok);
        check("flush_done", ok, 1);
        check("flush_nwr", evq.size(), 2);
        if (evq.size() == 2) begin
            check("flush_wb0", evq[0], {1'b1, 32'h04, 32'h1111_0004});
            check("flush_wb1", evq[1], {1'b1, 32'h08, 32'h2222_0008});
        end
        repeat (3) @(negedge CLK);
        check("flushed_sticky", flushed, 1);
        evq.delete();
        access(1, 0, 0, 32'h40, 0, 5, ld, cyc, ok);
        check("done_no_hit", ok, 0);
        check("done_no_traffic", evq.size(), 0);
        halt = 1'b0;
        do_reset();
        @(negedge CLK);
        check("rst_clears_flushed", flushed, 0);

        // randomized traffic against the word-level model
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 63)) << 2;
            d = $urandom;
            kind = $urandom_range(0, 2);
            mem_lat = $urandom_range(0, 3);
            e = expv(a);
            access(kind != 1, kind != 0, 0, a, d, 60, ld, cyc, ok);
            check("rnd_ok", ok, 1);
            check("rnd_load", ld, e);
            if (kind != 0) model[a] = d;
        end

`ifdef DCACHE_LLSC_EN
        mem_lat = 2;
        e = expv(32'h100);
        access(1, 0, 1, 32'h100, 0, 60, ld, cyc, ok);
        check("ll_load", ld, e);
        access(0, 1, 1, 32'h100, 32'h7, 60, ld, cyc, ok);
        check("sc_success", ld, 1);
        model[32'h100] = 32'h7;
        access(1, 0, 0, 32'h100, 0, 60, ld, cyc, ok);
        check("sc_stored", ld, 32'h7);
        access(1, 0, 1, 32'h100, 0, 60, ld, cyc, ok);
        access(0, 1, 0, 32'h100, 32'h9, 60, ld, cyc, ok);
        model[32'h100] = 32'h9;
        evq.delete();
        access(0, 1, 1, 32'h100, 32'h7, 60, ld, cyc, ok);
        check("sc_fail_hit", ok, 1);
        check("sc_fail_load", ld, 0);
        check("sc_fail_cycles", cyc, 1);
        check("sc_fail_no_traffic", evq.size(), 0);
        access(1, 0, 0, 32'h100, 0, 60, ld, cyc, ok);
        check("sc_fail_kept", ld, 32'h9);
`else
        mem_lat = 2;
        e = expv(32'h100);
        access(0, 1, 1, 32'h100, 32'h0BAD_F00D, 60, ld, cyc, ok);
        check("atomic_ignored_ok", ok, 1);
        check("atomic_ignored_old", ld, e);
        model[32'h100] = 32'h0BAD_F00D;
        access(1, 0, 1, 32'h100, 0, 60, ld, cyc, ok);
        check("atomic_ignored_rd", ld, 32'h0BAD_F00D);
`endif

        // final flush: memory must hold every written word
        mem_lat = 1;
        flush_wait(cyc, ok);
        check("final_flush", ok, 1);
        foreach (model[k]) check("final_mem", memrd(k), model[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
Direct-mapped, write-back, write-allocate data cache. It is the responder on the datapath's dcache port: it takes dmemREN/dmemWEN/dmemaddr/dmemstore/halt and returns dhit/dmemload/flushed. On misses and on the halt flush it acts as the initiator on the memory-controller side (dREN/dWEN/daddr/dstore in, dwait/dload back). One-word blocks; sits between the datapath and the cache controller.

Parameters:
SETS, 16, number of lines; power of 2, minimum 2; IDXW = log2(SETS).
WORDW, 32, word width (word_t).

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset
halt  in  1  datapath halt; triggers flush
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request
datomic  in  1  LL/SC qualifier (see Optional Feature)
dmemaddr  in  32  byte address; bits[1:0] ignored
dmemstore  in  32  write data
dhit  out  1  request satisfied this cycle
dmemload  out  32  read data / SC result
flushed  out  1  flush complete, sticky
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data
dwait  in  1  memory busy; transfer completes on a cycle with dwait=0
dload  in  32  memory read data

Behaviour:
- Address split: index = dmemaddr[IDXW+1:2]; tag = dmemaddr[31:IDXW+2]; per line valid, dirty, tag, data.
- Reset (nRST=0 at posedge): all valid/dirty = 0, state = IDLE, flush counter = 0. Outputs are 0 after reset: dhit, flushed, dREN, dWEN, daddr, dstore, dmemload. Reset mid-transaction aborts it, and dREN/dWEN are low the next cycle.
- State machine states: IDLE, WB, FETCH, FLUSH, FLUSH_WB, DONE.
- IDLE, request (REN|WEN), halt=0:
  - A hit is valid && tag match. dhit=1 combinationally in the same cycle; dmemload = line data.
  - On a write hit, data <= dmemstore and dirty <= 1 at the edge.
  - If REN and WEN are both high, the request is treated as a write.
  - No request: dhit=0, dmemload=0.
- Miss (request present, no hit):
  - If the victim is valid && dirty, go to WB; otherwise go to FETCH. dhit=0.
- WB: dWEN=1, daddr = {victim tag, index, 2'b00}, dstore = victim data. On dwait=0, clear dirty and go to FETCH.
- FETCH: dREN=1, daddr = {dmemaddr[31:2], 2'b00}. On dwait=0, install line (valid=1, dirty=0, tag, data=dload) and go to IDLE. The request then hits the next cycle.
- The datapath holds its request stable until dhit. A request dropped mid-miss still completes the fill.
- halt=1 in IDLE has priority over any request: go to FLUSH, counter = 0, dhit=0 from then on.
- FLUSH: if line[counter] is dirty, go to FLUSH_WB. Otherwise, if counter = SETS-1, go to DONE; else increment counter.
- FLUSH_WB: dWEN=1 with that line's address and data. On dwait=0, clear dirty, then advance or go to DONE using the same rule as FLUSH.
- halt rising during WB/FETCH takes effect after return to IDLE.
- DONE: flushed=1, sticky until reset. All requests are ignored (dhit=0) and no memory traffic occurs.
- dREN and dWEN are never high together. Both are registered state decodes, stable while dwait=1.

Optional Feature:
- Macro: DCACHE_LLSC_EN.
- Defined:
  - One link register (valid + word address).
  - LL (datomic & REN) behaves as a normal read and, on its dhit cycle, sets link = address, valid = 1.
  - SC (datomic & WEN): if link valid and address matches, it performs a normal write (including the miss path) and dmemload = 1 on dhit. If it fails, dhit=1 in IDLE with no write, no memory traffic, and dmemload = 0.
  - Any successful write (normal or SC) to the linked word clears link valid. Reset and halt clear the link.
- Undefined: datomic is ignored; all accesses are ordinary reads/writes.

Test Plan:
- Cold read 0x0000_0040, memory returns 0xDEAD_BEEF after 3 dwait cycles -> dREN for 4 cycles, then dhit=1 with dmemload=0xDEAD_BEEF; a second read hits with zero memory traffic.
- Write 0x1234_5678 to 0x40 (hit), then read 0x80 with SETS=16 (same index 0, different tag) -> dWEN with daddr=0x40 and dstore=0x1234_5678, then dREN with daddr=0x80.
- Write misses to 0x04 and 0x08, then halt=1 -> FLUSH_WB issues exactly two dWEN transfers (0x04, 0x08); flushed=1 about SETS+2 cycles later and stays high; later requests give dhit=0.
- nRST=0 asserted while FETCH is waiting on dwait=1 -> next cycle dREN=0, all outputs 0; the former address now misses.
- dmemREN=dmemWEN=1 on a hit at 0x40 with store 0xA5A5_A5A5 -> treated as a write; line updated and dirty.
- DCACHE_LLSC_EN, LL at 0x100 then SC 0x7 to 0x100:
  - No intervening write -> dmemload=1, value stored.
  - Intervening normal write to 0x100 -> SC gives dhit=1, dmemload=0, and memory keeps the prior value.
